// File: rtl/krz_map_pkg.sv
// rtl/krz_map_pkg.sv - shared krz SoC constants and UART receiver FSM encoding
package krz_map_pkg;

    localparam int UART_RX_DIV_MIN = 3;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

endpackage

// File: rtl/krz_uart_rx_if.sv
// rtl/krz_uart_rx_if.sv - receive-byte pop interface between UART RX and bus wrapper
interface krz_uart_rx_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [CW-1:0] fifo_count;

    modport master (output rd_data, output rd_valid, output fifo_count, input rd_ready);
    modport slave  (input rd_data, input rd_valid, input fifo_count, output rd_ready);
endinterface

// File: rtl/krz_fifo_fwft.sv
// rtl/krz_fifo_fwft.sv - first-word-fall-through FIFO with occupancy count and drop strobe
module krz_fifo_fwft #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                    clk,
    input  logic                    rstz,
    input  logic                    push,
    input  logic [W-1:0]            push_data,
    input  logic                    pop,
    output logic [W-1:0]            head,
    output logic                    valid,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_pop;
    logic         do_push;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign drop    = push && !do_push;
    assign valid   = (count != '0);
    assign head    = valid ? mem[rptr[AW-1:0]] : '0;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + ONE;
            if (do_pop)  rptr <= rptr + ONE;
            if (do_push && !do_pop)
                count <= count + ONE;
            else if (do_pop && !do_push)
                count <= count - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/krz_uart_rx.sv
// rtl/krz_uart_rx.sv - 8N1 UART receiver with runtime divider and FWFT byte buffer
module krz_uart_rx
    import krz_map_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DIVW  = 16
) (
    input  logic             clk,
    input  logic             rstz,
    input  logic             rx,
    input  logic             cfg_en,
    input  logic [DIVW-1:0]  cfg_clk_div,
    krz_uart_rx_if.master    rd,
    output logic             frame_err,
    output logic             overrun
);
    localparam logic [DIVW-1:0] DIV_MIN = DIVW'(UART_RX_DIV_MIN);

    logic            sync1;
    logic            rxs;
    rx_state_e       state, state_n;
    logic [DIVW-1:0] cnt, cnt_n;
    logic [2:0]      bitidx, bitidx_n;
    logic [7:0]      shreg, shreg_n;
    logic [DIVW-1:0] div;
    logic [DIVW-1:0] half;
    logic            tick;
    logic            push;

    // Divider is re-read at every reload so a new rate applies from the next bit on.
    assign div  = (cfg_clk_div < DIV_MIN) ? DIV_MIN : cfg_clk_div;
    assign half = div >> 1;
    assign tick = (cnt == '0);

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state  <= RX_IDLE;
            cnt    <= '0;
            bitidx <= '0;
            shreg  <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            bitidx <= bitidx_n;
            shreg  <= shreg_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = tick ? cnt : cnt - 1'b1;
        bitidx_n  = bitidx;
        shreg_n   = shreg;
        push      = 1'b0;
        frame_err = 1'b0;
        if (!cfg_en) begin
            state_n = RX_IDLE;
        end else begin
            case (state)
                RX_IDLE: begin
                    if (!rxs) begin
                        cnt_n   = half;
                        state_n = RX_START;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (!rxs) begin
                            cnt_n    = div;
                            bitidx_n = '0;
                            state_n  = RX_DATA;
                        end else begin
                            state_n = RX_IDLE;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        shreg_n  = {rxs, shreg[7:1]};
                        cnt_n    = div;
                        bitidx_n = bitidx + 3'd1;
                        if (bitidx == 3'd7) state_n = RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        if (rxs) begin
                            push    = 1'b1;
                            state_n = RX_IDLE;
                        end else begin
                            frame_err = 1'b1;
                            state_n   = RX_BREAK;
                        end
                    end
                end
                RX_BREAK: begin
                    // Hold here while the line stays low so a break reports only once.
                    if (rxs) state_n = RX_IDLE;
                end
                default: state_n = RX_IDLE;
            endcase
        end
    end

    krz_fifo_fwft #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .clk       (clk),
        .rstz      (rstz),
        .push      (push),
        .push_data (shreg),
        .pop       (rd.rd_ready),
        .head      (rd.rd_data),
        .valid     (rd.rd_valid),
        .count     (rd.fifo_count),
        .drop      (overrun)
    );

endmodule
